// File: rtl/conv3x3_pkg.sv
// conv3x3_pkg: shared widths, coefficient addresses, FSM states and the
// signed pixel-by-coefficient product helper for the 3x3 convolution engine.
package conv3x3_pkg;

    localparam int ACC_W    = 24;
    localparam int PROD_W   = 17;
    localparam int ROW_W    = 19;
    localparam int NUM_TAPS = 9;
    localparam int NUM_COEF = 10;

    localparam logic [3:0] ADDR_BIAS = 4'd9;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Unsigned pixel times signed 8-bit coefficient; exact in 17 bits.
    function automatic logic signed [PROD_W-1:0] tap_mul(
        input logic [7:0] px,
        input logic [7:0] k
    );
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        a = PROD_W'($signed({1'b0, px}));
        b = PROD_W'($signed(k));
        return a * b;
    endfunction

endpackage

// File: rtl/conv3x3_adder_tree.sv
// conv3x3_adder_tree: registered two-stage sum of nine products plus bias.
// Ports: clk, rst (sync high), in_valid, products (9 x 17b packed, tap 0 in LSBs),
//        bias (signed 16b), out_valid, acc (signed OUT_W b).
module conv3x3_adder_tree
    import conv3x3_pkg::*;
#(
    parameter int OUT_W = ACC_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [NUM_TAPS*PROD_W-1:0]   products,
    input  logic [15:0]                  bias,
    output logic                         out_valid,
    output logic [OUT_W-1:0]             acc
);

    logic signed [PROD_W-1:0] p [NUM_TAPS];
    logic signed [ROW_W-1:0]  r0;
    logic signed [ROW_W-1:0]  r1;
    logic signed [ROW_W-1:0]  r2;
    logic signed [15:0]       bias_q;
    logic                     row_valid;

    always_comb begin
        for (int i = 0; i < NUM_TAPS; i++) begin
            p[i] = $signed(products[i*PROD_W +: PROD_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_valid <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            row_valid <= in_valid;
            out_valid <= row_valid;
        end
    end

    // Row sums: one row of the window per adder.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r0     <= ROW_W'(p[0]) + ROW_W'(p[1]) + ROW_W'(p[2]);
            r1     <= ROW_W'(p[3]) + ROW_W'(p[4]) + ROW_W'(p[5]);
            r2     <= ROW_W'(p[6]) + ROW_W'(p[7]) + ROW_W'(p[8]);
            bias_q <= $signed(bias);
        end
    end

    always_ff @(posedge clk) begin
        if (row_valid) begin
            acc <= OUT_W'(r0) + OUT_W'(r1) + OUT_W'(r2) + OUT_W'(bias_q);
        end
    end

endmodule

// File: rtl/conv3x3_engine.sv
// conv3x3_engine: 3x3 signed convolution with bias, shift requant, ReLU and
// 8-bit saturation; coefficient LOAD/RUN control and output position tracking.
// Ports: clk, rst (sync high), in_valid, w0..w8 (window, row-major),
//        wt_we/wt_addr/wt_data (coefficient writes), wt_commit, wt_clear,
//        ready, out_valid, out_pixel, out_col, out_row, frame_done.
module conv3x3_engine #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int SHIFT      = 7,
    parameter int ACC_W      = conv3x3_pkg::ACC_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  w0,
    input  logic [7:0]  w1,
    input  logic [7:0]  w2,
    input  logic [7:0]  w3,
    input  logic [7:0]  w4,
    input  logic [7:0]  w5,
    input  logic [7:0]  w6,
    input  logic [7:0]  w7,
    input  logic [7:0]  w8,
    input  logic        wt_we,
    input  logic [3:0]  wt_addr,
    input  logic [15:0] wt_data,
    input  logic        wt_commit,
    input  logic        wt_clear,
    output logic        ready,
    output logic        out_valid,
    output logic [7:0]  out_pixel,
    output logic [5:0]  out_col,
    output logic [5:0]  out_row,
    output logic        frame_done
);

    import conv3x3_pkg::*;

    localparam logic signed [ACC_W-1:0] PX_MAX = ACC_W'(255);

    state_t state;
    state_t state_nx;

    logic [NUM_COEF-1:0]        loaded;
    logic [7:0]                 kern [NUM_TAPS];
    logic [15:0]                bias;
    logic [7:0]                 win [NUM_TAPS];

    logic                       clear_req;
    logic                       win_take;

    logic                       s1_valid;
    logic [NUM_TAPS*PROD_W-1:0] s1_prod;
    logic [15:0]                s1_bias;

    logic                       acc_valid;
    logic [ACC_W-1:0]           acc;
    logic signed [ACC_W-1:0]    shifted;
    logic [7:0]                 sat_px;

    logic [5:0]                 cnt_col;
    logic [5:0]                 cnt_row;
    logic                       col_last;
    logic                       row_last;

    assign win = '{w0, w1, w2, w3, w4, w5, w6, w7, w8};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD: if (wt_commit && (&loaded)) state_nx = RUN;
            RUN:  if (wt_clear) state_nx = LOAD;
        endcase
    end

    assign ready     = (state == RUN);
    assign clear_req = (state == RUN) && wt_clear;
    // A clear in the same cycle drops the window.
    assign win_take  = (state == RUN) && in_valid && !wt_clear;

    // Coefficients are writable only in LOAD; values survive a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            loaded <= '0;
            bias   <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                kern[i] <= '0;
            end
        end else if (state == LOAD) begin
            if (wt_we) begin
                for (int i = 0; i < NUM_TAPS; i++) begin
                    if (wt_addr == 4'(i)) begin
                        kern[i]   <= wt_data[7:0];
                        loaded[i] <= 1'b1;
                    end
                end
                if (wt_addr == ADDR_BIAS) begin
                    bias                 <= wt_data;
                    loaded[NUM_COEF-1]   <= 1'b1;
                end
            end
        end else if (clear_req) begin
            loaded <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= win_take;
        end
    end

    // Bias travels with its window so a reload during drain cannot leak in.
    always_ff @(posedge clk) begin
        if (win_take) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                s1_prod[i*PROD_W +: PROD_W] <= tap_mul(win[i], kern[i]);
            end
            s1_bias <= bias;
        end
    end

    conv3x3_adder_tree #(
        .OUT_W (ACC_W)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .products  (s1_prod),
        .bias      (s1_bias),
        .out_valid (acc_valid),
        .acc       (acc)
    );

    always_comb begin
        shifted = $signed(acc) >>> SHIFT;
        if (shifted[ACC_W-1]) begin
            sat_px = 8'd0;
        end else if (shifted > PX_MAX) begin
            sat_px = 8'hff;
        end else begin
            sat_px = shifted[7:0];
        end
    end

    assign col_last = (cnt_col == 6'(IMG_WIDTH - 3));
    assign row_last = (cnt_row == 6'(IMG_HEIGHT - 3));

    // cnt_* hold the position of the next pixel to be emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_col    <= '0;
            out_row    <= '0;
            frame_done <= 1'b0;
            cnt_col    <= '0;
            cnt_row    <= '0;
        end else begin
            out_valid  <= acc_valid;
            frame_done <= 1'b0;
            if (acc_valid) begin
                out_pixel  <= sat_px;
                out_col    <= cnt_col;
                out_row    <= cnt_row;
                frame_done <= col_last && row_last;
                if (col_last) begin
                    cnt_col <= '0;
                    cnt_row <= row_last ? 6'd0 : cnt_row + 6'd1;
                end else begin
                    cnt_col <= cnt_col + 6'd1;
                end
            end
            if (clear_req) begin
                cnt_col <= '0;
                cnt_row <= '0;
            end
        end
    end

endmodule
